oserdes_fr_tx_phy: RTL and testbench



---
 rtl/oserdes_fr_pkg.sv | 34 +++
 rtl/oserdes_lane_shift.sv | 27 ++
 rtl/oserdes_fr_tx_phy.sv | 160 ++++++++++++++++
 tb/tb_oserdes_fr_tx_phy.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oserdes_fr_pkg.sv
// Shared types and constants for the frame-aligned
// transmit serializer.
package oserdes_fr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } fr_state_e;

  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hF0;
  localparam logic [7:0] DEF_IDLE_WORD     = 8'h00;

  // Lane word width for a given output mode.
  function automatic int unsigned lane_width(
    input int unsigned mode
  );
    case (mode)
      0:       return 8;
      1:       return 7;
      2:       return 6;
      3:       return 1;
      default: return 8;
    endcase
  endfunction

  // Counter width able to hold 0..w-1 (at least 1 bit).
  function automatic int unsigned cnt_width(
    input int unsigned w
  );
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/oserdes_lane_shift.sv
// One serial lane: W-bit load/shift register, MSB
// first, with a registered serial output.
module oserdes_lane_shift #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         dout
);

  logic [W-1:0] sr;

  // Load a word at a boundary, otherwise shift left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr   <= '0;
      dout <= 1'b0;
    end else begin
      dout <= sr[W-1];
      if (load) sr <= load_data;
      else      sr <= sr << 1;
    end
  end

endmodule

// File: rtl/oserdes_fr_tx_phy.sv
// Bit-rate serializer: two MSB-first lanes plus a
// frame line, fed by a one-entry holding register.
module oserdes_fr_tx_phy
  import oserdes_fr_pkg::*;
#(
  parameter int unsigned OUTPUT_MODE   = 0,
  parameter logic [7:0]  TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter logic [7:0]  IDLE_WORD     = DEF_IDLE_WORD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        train,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        dout_a,
  output logic        dout_b,
  output logic        frame,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned W  = lane_width(OUTPUT_MODE);
  localparam int unsigned CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW:0]   HALF     = (CW+1)'((W + 1) / 2);

  fr_state_e     state;
  fr_state_e     nxt;
  logic [CW-1:0] cnt;
  logic          boundary;

  logic          hold_valid;
  logic [W-1:0]  hold_a;
  logic [W-1:0]  hold_b;
  logic          take;
  logic          consume;
  logic          starve;

  logic [W-1:0]  load_a;
  logic [W-1:0]  load_b;

  assign din_ready = !hold_valid;
  assign take      = din_valid && !hold_valid;
  assign boundary  = (state == ST_IDLE) ||
                     (cnt == CNT_LAST);

  // State register and in-word bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state != ST_IDLE) begin
        if (cnt == CNT_LAST) cnt <= '0;
        else                 cnt <= cnt + 1'b1;
      end
    end
  end

  // Mode changes only at word boundaries.
  always_comb begin
    nxt = state;
    if (boundary) begin
      unique case (1'b1)
        !enable:          nxt = ST_IDLE;
        enable && train:  nxt = ST_TRAIN;
        enable && !train: nxt = ST_RUN;
        default:          nxt = state;
      endcase
    end
  end

  // Pick the next lane words from the mode being entered.
  always_comb begin
    load_a  = '0;
    load_b  = '0;
    consume = 1'b0;
    starve  = 1'b0;
    unique case (nxt)
      ST_TRAIN: begin
        load_a = TRAIN_PATTERN[W-1:0];
        load_b = TRAIN_PATTERN[W-1:0];
      end
      ST_RUN: begin
        if (hold_valid) begin
          load_a  = hold_a;
          load_b  = hold_b;
          consume = boundary;
        end else begin
          load_a = IDLE_WORD[W-1:0];
          load_b = IDLE_WORD[W-1:0];
          starve = boundary;
        end
      end
      default: begin
        load_a = '0;
        load_b = '0;
      end
    endcase
  end

  // Holding register; filled in any state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_a     <= '0;
      hold_b     <= '0;
    end else begin
      if (consume) hold_valid <= 1'b0;
      if (take) begin
        hold_valid <= 1'b1;
        hold_a     <= din[8 +: W];
        hold_b     <= din[0 +: W];
      end
    end
  end

  // Saturating count of starved RUN boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_cnt <= '0;
    end else if (starve &&
                 underflow_cnt != 16'hFFFF) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  // Frame high over the first half of each word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame <= 1'b0;
    end else begin
      frame <= (state != ST_IDLE) &&
               ({1'b0, cnt} < HALF);
    end
  end

  oserdes_lane_shift #(
    .W (W)
  ) u_lane_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (boundary),
    .load_data (load_a),
    .dout      (dout_a)
  );

  oserdes_lane_shift #(
    .W (W)
  ) u_lane_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (boundary),
    .load_data (load_b),
    .dout      (dout_b)
  );

endmodule

// File: tb/tb_oserdes_fr_tx_phy.sv
// Bench for the serializer: three widths (8, 7, 1)
// against a word-level stream model.
module tb_oserdes_fr_tx_phy;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        train = 1'b0;
  logic [15:0] din_v [3];
  logic        val_v [3];
  logic        da [3];
  logic        db [3];
  logic        fr [3];
  logic        rdy [3];
  logic [15:0] uf [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  oserdes_fr_tx_phy #(.OUTPUT_MODE(0)) u_w8 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .train(train), .din(din_v[0]),
    .din_valid(val_v[0]), .din_ready(rdy[0]),
    .dout_a(da[0]), .dout_b(db[0]), .frame(fr[0]),
    .underflow_cnt(uf[0]));

  oserdes_fr_tx_phy #(.OUTPUT_MODE(1)) u_w7 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .train(train), .din(din_v[1]),
    .din_valid(val_v[1]), .din_ready(rdy[1]),
    .dout_a(da[1]), .dout_b(db[1]), .frame(fr[1]),
    .underflow_cnt(uf[1]));

  oserdes_fr_tx_phy #(.OUTPUT_MODE(3)) u_w1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .train(train), .din(din_v[2]),
    .din_valid(val_v[2]), .din_ready(rdy[2]),
    .dout_a(da[2]), .dout_b(db[2]), .frame(fr[2]),
    .underflow_cnt(uf[2]));

  // model: mode 0 idle, 1 train, 2 run
  int          m_mode [3];
  int          m_pos [3];
  bit          m_hv [3];
  logic [15:0] m_hd [3];
  int          m_uf [3];
  logic [2:0]  m_exp [3];
  logic [2:0]  qb [3][32];
  int          qh [3];
  int          qn [3];

  // sources
  logic [15:0] src_word [3];
  int          src_left [3];
  bit          src_rand = 1'b0;

  logic [7:0] cap_a, cap_b, cap_f;

  function automatic int wid(input int k);
    return (k == 0) ? 8 : (k == 1) ? 7 : 1;
  endfunction

  task automatic chk(input string tag, input int k,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed %h expected %h",
             tag, k, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [2:0] v);
    qb[k][(qh[k] + qn[k]) % 32] = v;
    qn[k]++;
  endtask

  task automatic model_step(input int k);
    int w;
    int nm;
    bit bnd;
    bit tk;
    logic [7:0] wa, wb;
    w = wid(k);
    bnd = (m_mode[k] == 0) || (m_pos[k] == w - 1);
    if (qn[k] > 0) begin
      m_exp[k] = qb[k][qh[k]];
      qh[k] = (qh[k] + 1) % 32;
      qn[k]--;
    end else begin
      m_exp[k] = 3'b000;
    end
    tk = val_v[k] && !m_hv[k];
    nm = m_mode[k];
    if (bnd) begin
      nm = !enable ? 0 : (train ? 1 : 2);
      if (nm == 0) begin
        push(k, 3'b000);
      end else begin
        wa = 8'hF0;
        wb = 8'hF0;
        if (nm == 2) begin
          if (m_hv[k]) begin
            wa = m_hd[k][15:8];
            wb = m_hd[k][7:0];
            m_hv[k] = 1'b0;
          end else begin
            wa = 8'h00;
            wb = 8'h00;
            if (m_uf[k] < 65535) m_uf[k]++;
          end
        end
        for (int i = 0; i < w; i++)
          push(k, {wa[w-1-i], wb[w-1-i],
                   1'(i < (w + 1) / 2)});
      end
    end
    if (tk) begin
      m_hv[k] = 1'b1;
      m_hd[k] = din_v[k];
    end
    if (m_mode[k] != 0) m_pos[k] = (m_pos[k] + 1) % w;
    m_mode[k] = nm;
  endtask

  task automatic drive(input int k);
    val_v[k] = (src_left[k] > 0) &&
               (!src_rand || $urandom_range(0, 3) != 0);
    din_v[k] = val_v[k] ? src_word[k] : 16'($urandom);
  endtask

  task automatic setsrc(input int k, input logic [15:0] w,
                        input int n);
    src_word[k] = w;
    src_left[k] = n;
    drive(k);
  endtask

  task automatic cyc();
    bit tk [3];
    for (int k = 0; k < 3; k++) begin
      chk("din_ready", k, 16'(rdy[k]), 16'(!m_hv[k]));
      tk[k] = val_v[k] && rdy[k];
      model_step(k);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("dout_a", k, 16'(da[k]), 16'(m_exp[k][2]));
      chk("dout_b", k, 16'(db[k]), 16'(m_exp[k][1]));
      chk("frame", k, 16'(fr[k]), 16'(m_exp[k][0]));
      chk("underflow", k, uf[k], 16'(m_uf[k]));
      if (tk[k]) begin
        src_left[k]--;
        if (src_rand) src_word[k] = 16'($urandom);
        else          src_word[k] = src_word[k] + 16'h0202;
      end
      drive(k);
    end
  endtask

  task automatic cap1(input int k);
    cyc();
    cap_a = {cap_a[6:0], da[k]};
    cap_b = {cap_b[6:0], db[k]};
    cap_f = {cap_f[6:0], fr[k]};
  endtask

  task automatic cap_clr();
    cap_a = '0;
    cap_b = '0;
    cap_f = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    train = 1'b0;
    for (int k = 0; k < 3; k++) begin
      src_left[k] = 0;
      src_word[k] = '0;
      drive(k);
      m_mode[k] = 0;
      m_pos[k] = 0;
      m_hv[k] = 1'b0;
      m_hd[k] = '0;
      m_uf[k] = 0;
      qh[k] = 0;
      qn[k] = 0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_dout_a", k, 16'(da[k]), 16'h0);
      chk("rst_dout_b", k, 16'(db[k]), 16'h0);
      chk("rst_frame", k, 16'(fr[k]), 16'h0);
      chk("rst_ready", k, 16'(rdy[k]), 16'h1);
      chk("rst_underflow", k, uf[k], 16'h0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // single word A53C, pre-loaded in IDLE
    do_reset();
    src_rand = 1'b0;
    setsrc(0, 16'hA53C, 1);
    cyc();
    enable = 1'b1;
    cyc();
    cap_clr();
    repeat (8) cap1(0);
    chk("a53c_lane_a", 0, 16'(cap_a), 16'h00A5);
    chk("a53c_lane_b", 0, 16'(cap_b), 16'h003C);
    chk("a53c_frame", 0, 16'(cap_f), 16'h00F0);
    chk("a53c_uf1", 0, uf[0], 16'd1);
    repeat (8) cyc();
    chk("a53c_uf2", 0, uf[0], 16'd2);

    // back-to-back stream, no gaps
    do_reset();
    setsrc(0, 16'h0102, 3);
    cyc();
    enable = 1'b1;
    cyc();
    repeat (23) cyc();
    chk("stream_no_uf", 0, uf[0], 16'd0);
    repeat (2) cyc();
    chk("stream_end_uf", 0, uf[0], 16'd1);
    enable = 1'b0;
    repeat (10) cyc();

    // training, then train drops mid-word
    do_reset();
    setsrc(0, 16'hC35A, 1);
    train = 1'b1;
    enable = 1'b1;
    cyc();
    cap_clr();
    repeat (8) cap1(0);
    chk("train_lane_a", 0, 16'(cap_a), 16'h00F0);
    chk("train_lane_b", 0, 16'(cap_b), 16'h00F0);
    repeat (3) cyc();
    train = 1'b0;
    repeat (5) cyc();
    cap_clr();
    repeat (8) cap1(0);
    chk("post_train_a", 0, 16'(cap_a), 16'h00C3);
    chk("post_train_b", 0, 16'(cap_b), 16'h005A);

    // seven-bit lanes
    do_reset();
    setsrc(1, 16'h7F00, 1);
    cyc();
    enable = 1'b1;
    cyc();
    cap_clr();
    repeat (7) cap1(1);
    chk("w7_lane_a", 1, 16'(cap_a), 16'h007F);
    chk("w7_lane_b", 1, 16'(cap_b), 16'h0000);
    chk("w7_frame", 1, 16'(cap_f), 16'h0078);

    // enable drops mid-word: word completes
    do_reset();
    setsrc(0, 16'hFF81, 1);
    cyc();
    enable = 1'b1;
    cyc();
    cap_clr();
    for (int i = 0; i < 8; i++) begin
      cap1(0);
      if (i == 2) enable = 1'b0;
    end
    chk("stop_lane_a", 0, 16'(cap_a), 16'h00FF);
    chk("stop_lane_b", 0, 16'(cap_b), 16'h0081);
    cyc();
    chk("stop_idle_dout", 0, 16'(da[0]), 16'h0);
    chk("stop_idle_frame", 0, 16'(fr[0]), 16'h0);

    // enable glitch inside one word, no idle gap
    setsrc(0, 16'h1234, 2);
    cyc();
    enable = 1'b1;
    repeat (2) cyc();
    enable = 1'b0;
    repeat (2) cyc();
    enable = 1'b1;
    repeat (20) cyc();

    // reset in the middle of a word
    setsrc(0, 16'h5AA5, 1);
    repeat (5) cyc();
    do_reset();

    // randomized traffic
    src_rand = 1'b1;
    for (int k = 0; k < 3; k++)
      setsrc(k, 16'($urandom), 100000);
    enable = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) enable = !enable;
      if ($urandom_range(0, 29) == 0) train = !train;
      cyc();
    end

    // underflow saturation on the 1-bit instance
    do_reset();
    src_rand = 1'b0;
    enable = 1'b1;
    repeat (65545) cyc();
    chk("uf_saturate", 2, uf[2], 16'hFFFF);

    $display("%0d/%0d checks passed",
             n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
